vga_timing_gen: RTL and testbench

//  Source end of the VGA pixel interface: produces hCount/vCount, Bright, hSync, vSync for 640x480@60.

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_pix_tick.sv | 31 +++
 rtl/vga_timing_gen.sv | 117 +++++++++++
 tb/tb_vga_timing_gen.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared constants for the VGA pixel interface.
//   - Default 640x480@60 timing (pixel divider, sync, porches, active sizes).
//   - Derived visible-window bounds for the default timing.
//   - Colour constants shared with the display blocks (12-bit RGB 4:4:4).
package vga_pkg;

    localparam int PIX_DIV_DEF  = 4;
    localparam int H_TOTAL_DEF  = 800;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_TOTAL_DEF  = 525;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_ACTIVE_DEF = 480;

    localparam logic [9:0] H_VIS_START = 10'(H_SYNC_DEF + H_BP_DEF);
    localparam logic [9:0] H_VIS_END   = 10'(H_SYNC_DEF + H_BP_DEF + H_ACTIVE_DEF - 1);
    localparam logic [9:0] V_VIS_START = 10'(V_SYNC_DEF + V_BP_DEF);
    localparam logic [9:0] V_VIS_END   = 10'(V_SYNC_DEF + V_BP_DEF + V_ACTIVE_DEF - 1);

    typedef logic [11:0] rgb_t;

    localparam rgb_t COL_BLACK  = 12'h000;
    localparam rgb_t COL_WHITE  = 12'hFFF;
    localparam rgb_t COL_RED    = 12'hF00;
    localparam rgb_t COL_GREEN  = 12'h0F0;
    localparam rgb_t COL_BLUE   = 12'h00F;
    localparam rgb_t COL_YELLOW = 12'hFF0;

endpackage

// File: rtl/vga_pix_tick.sv
// vga_pix_tick: pixel-rate enable generator.
//   Clk     in  system clock
//   Reset   in  synchronous, active-high; divider restarts at 0
//   pixTick out high on the last Clk of each pixel (d == PIX_DIV-1)
// With PIX_DIV=1 the divider never leaves 0, so pixTick is constantly 1.
module vga_pix_tick #(
    parameter int PIX_DIV = 4   // legal 1..16
) (
    input  logic Clk,
    input  logic Reset,
    output logic pixTick
);

    localparam logic [3:0] D_MAX = 4'(PIX_DIV - 1);

    logic [3:0] d_q, d_d;

    always_comb begin
        d_d = d_q;
        if (d_q == D_MAX) d_d = '0;
        else              d_d = d_q + 4'd1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) d_q <= '0;
        else       d_q <= d_d;
    end

    assign pixTick = (d_q == D_MAX);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: source end of the VGA pixel interface (640x480@60 default).
//   Clk         in   system clock
//   Reset       in   synchronous, active-high
//   pixTick     out  pixel enable; counters advance on the next edge
//   hCount      out  10b horizontal position 0..H_TOTAL-1
//   vCount      out  10b vertical position 0..V_TOTAL-1
//   hSync       out  active-low horizontal sync
//   vSync       out  active-low vertical sync
//   Bright      out  high inside the visible window
//   frameStart  out  1-Clk pulse on the last pixel of the frame, with pixTick
//   frameCount  out  16b frame counter
// Config macro: VGA_FRAME_CNT_EN builds the frame counter; otherwise
// frameCount is tied to zero (port list unchanged).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int PIX_DIV  = PIX_DIV_DEF,
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic        pixTick,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        hSync,
    output logic        vSync,
    output logic        Bright,
    output logic        frameStart,
    output logic [15:0] frameCount
);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_N = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_N = 10'(V_SYNC);
    localparam logic [9:0] H_VIS_LO = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_VIS_HI = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0] V_VIS_LO = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_VIS_HI = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

    vga_pix_tick #(.PIX_DIV(PIX_DIV)) u_pix_tick (
        .Clk     (Clk),
        .Reset   (Reset),
        .pixTick (pixTick)
    );

    logic [9:0] h_q, h_d, v_q, v_d;
    logic       hsync_q, hsync_d, vsync_q, vsync_d, bright_q, bright_d;

    // Sync/Bright are decoded from the next counter values so that the
    // registered outputs line up with the counters in the same cycle.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pixTick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
        hsync_d  = (h_d >= H_SYNC_N);
        vsync_d  = (v_d >= V_SYNC_N);
        bright_d = (h_d >= H_VIS_LO) && (h_d <= H_VIS_HI) &&
                   (v_d >= V_VIS_LO) && (v_d <= V_VIS_HI);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            h_q      <= '0;
            v_q      <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            bright_q <= 1'b0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            bright_q <= bright_d;
        end
    end

    assign hCount     = h_q;
    assign vCount     = v_q;
    assign hSync      = hsync_q;
    assign vSync      = vsync_q;
    assign Bright     = bright_q;
    assign frameStart = pixTick && (h_q == H_LAST) && (v_q == V_LAST);

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] fcnt_q, fcnt_d;

    always_comb begin
        fcnt_d = fcnt_q;
        if (frameStart) fcnt_d = fcnt_q + 16'd1;   // wraps 0xFFFF -> 0
    end

    always_ff @(posedge Clk) begin
        if (Reset) fcnt_q <= '0;
        else       fcnt_q <= fcnt_d;
    end

    assign frameCount = fcnt_q;
`else
    assign frameCount = 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench. Instance A uses the default 640x480 timing (PIX_DIV=4) for
// reset, divider, line and mid-pixel reset behaviour. Instance B uses a tiny
// frame (20x10, PIX_DIV=1) so whole frames, the Bright window, the frame corner
// and the frame counter can be exercised within a short run.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic        pt_a, hs_a, vs_a, br_a, fs_a;
    logic [9:0]  hc_a, vc_a;
    logic [15:0] fc_a;
    logic        pt_b, hs_b, vs_b, br_b, fs_b;
    logic [9:0]  hc_b, vc_b;
    logic [15:0] fc_b;

    vga_timing_gen dut_a (
        .Clk(clk), .Reset(rst_a), .pixTick(pt_a), .hCount(hc_a), .vCount(vc_a),
        .hSync(hs_a), .vSync(vs_a), .Bright(br_a), .frameStart(fs_a), .frameCount(fc_a)
    );

    vga_timing_gen #(
        .PIX_DIV(1), .H_TOTAL(20), .H_SYNC(3), .H_BP(2), .H_ACTIVE(12),
        .V_TOTAL(10), .V_SYNC(2), .V_BP(2), .V_ACTIVE(5)
    ) dut_b (
        .Clk(clk), .Reset(rst_b), .pixTick(pt_b), .hCount(hc_b), .vCount(vc_b),
        .hSync(hs_b), .vSync(vs_b), .Bright(br_b), .frameStart(fs_b), .frameCount(fc_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    int prev_h, found, lows, bcnt, skew, wrap_at;
    int eh, ev, pos_err, hs_err, vs_err, br_err, fs_err, fc_err, pt_err;
    int br_tot, fs_tot, fs_k1, fs_k2;
    logic exp_br, exp_fs;
    int exp_fc, frames_done;

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_h", hc_a, 0);
        chk("rst_v", vc_a, 0);
        chk("rst_hs", hs_a, 0);
        chk("rst_vs", vs_a, 0);
        chk("rst_br", br_a, 0);
        chk("rst_pt", pt_a, 0);
        chk("rst_fs", fs_a, 0);
        chk("rst_fc", fc_a, 0);

        rst_a = 1'b0;
        rst_b = 1'b0;

        // Divider: pixTick on the 4th Clk after release, hCount=1 after it
        repeat (2) @(negedge clk);
        chk("tick_early", pt_a, 0);
        @(negedge clk);
        chk("tick_first", pt_a, 1);
        chk("h_before_tick", hc_a, 0);
        @(negedge clk);
        chk("h_after_tick", hc_a, 1);
        chk("pt_after_tick", pt_a, 0);

        // Align to the start of line 1
        found = 0;
        for (int i = 0; i < 4000 && found == 0; i++) begin
            prev_h = hc_a;
            @(negedge clk);
            if (prev_h == 799 && hc_a == 0) found = 1;
        end
        chk("align_line", found, 1);
        chk("v_line1", vc_a, 1);

        // One full line: sync width, Bright off, zero-skew sync, period 3200
        lows = 0; bcnt = 0; skew = 0; wrap_at = -1;
        for (int i = 0; i < 3200; i++) begin
            if (hs_a == 1'b0) lows++;
            if (br_a == 1'b1) bcnt++;
            if (hs_a !== (hc_a >= 10'd96)) skew++;
            if (i > 0 && prev_h == 799 && hc_a == 0) wrap_at = i;
            prev_h = hc_a;
            @(negedge clk);
        end
        chk("hs_low_clks", lows, 384);
        chk("bright_line1", bcnt, 0);
        chk("hs_skew", skew, 0);
        chk("no_early_wrap", wrap_at, 32'hFFFF_FFFF);
        chk("line_end_h", hc_a, 0);
        chk("line_end_v", vc_a, 2);
        chk("vs_line2", vs_a, 1);

        // Mid-pixel reset at hCount=400
        found = 0;
        for (int i = 0; i < 4000 && found == 0; i++) begin
            @(negedge clk);
            if (hc_a == 400) found = 1;
        end
        chk("reach_400", found, 1);
        @(negedge clk);
        chk("mid_pixel", pt_a, 0);
        chk("hs_pre_rst", hs_a, 1);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        chk("mrst_h", hc_a, 0);
        chk("mrst_v", vc_a, 0);
        chk("mrst_hs", hs_a, 0);
        chk("mrst_vs", vs_a, 0);
        chk("mrst_br", br_a, 0);
        chk("mrst_pt", pt_a, 0);
        repeat (2) @(negedge clk);
        chk("restart_early", pt_a, 0);
        @(negedge clk);
        chk("restart_tick", pt_a, 1);
        @(negedge clk);
        chk("restart_h", hc_a, 1);

        // Tiny-frame instance: restart, then run exactly 3 frames
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        pos_err = 0; hs_err = 0; vs_err = 0; br_err = 0; fs_err = 0; fc_err = 0; pt_err = 0;
        br_tot = 0; fs_tot = 0; fs_k1 = -1; fs_k2 = -1;
        for (int k = 0; k < 600; k++) begin
            eh = k % 20;
            ev = (k / 20) % 10;
            frames_done = k / 200;
            exp_br = (eh >= 5 && eh <= 16 && ev >= 4 && ev <= 8);
            exp_fs = (eh == 19 && ev == 9);
`ifdef VGA_FRAME_CNT_EN
            exp_fc = frames_done;
`else
            exp_fc = 0;
`endif
            if (hc_b != 10'(eh) || vc_b != 10'(ev)) pos_err++;
            if (hs_b !== (eh >= 3)) hs_err++;
            if (vs_b !== (ev >= 2)) vs_err++;
            if (br_b !== exp_br) br_err++;
            if (fs_b !== exp_fs) fs_err++;
            if (fc_b !== 16'(exp_fc)) fc_err++;
            if (pt_b !== 1'b1) pt_err++;
            if (br_b) br_tot++;
            if (fs_b) begin
                fs_tot++;
                if (fs_k1 < 0) fs_k1 = k;
                else if (fs_k2 < 0) fs_k2 = k;
            end
            @(negedge clk);
        end
        chk("b_pos", pos_err, 0);
        chk("b_hs", hs_err, 0);
        chk("b_vs", vs_err, 0);
        chk("b_bright", br_err, 0);
        chk("b_fs", fs_err, 0);
        chk("b_fc_track", fc_err, 0);
        chk("b_pt_const", pt_err, 0);
        chk("b_bright_tot", br_tot, 180);
        chk("b_fs_tot", fs_tot, 3);
        chk("b_fs_first", fs_k1, 199);
        chk("b_frame_period", fs_k2 - fs_k1, 200);
        chk("b_corner_h", hc_b, 0);
        chk("b_corner_v", vc_b, 0);
`ifdef VGA_FRAME_CNT_EN
        chk("b_fc_final", fc_b, 3);
`else
        chk("b_fc_final", fc_b, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
